// File: rtl/maxpool_window_gen_if.sv
// Pixel-in / window-out stream bundle for the 3x3 max-pool window generator.
// master = producer of pixels and consumer of windows; slave = the generator.
interface maxpool_window_gen_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_sof;
    logic              in_ready;
    logic [DATA_W-1:0] win [0:8];
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output in_data, in_valid, in_sof, out_ready,
        input  in_ready, win, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_sof, out_ready,
        output in_ready, win, out_valid, out_last
    );
endinterface

// File: rtl/maxpool_window_gen.sv
// Streaming 3x3 window generator for a raster-order pixel stream.
// Two line buffers hold the previous two rows; a 3x3 shift register collects
// one column per accepted pixel and a single output register presents every
// window that lands on the stride grid.
module maxpool_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int STRIDE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    maxpool_window_gen_if.slave  bus
);
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    // Bottom-right pixel of the final window on the stride grid.
    localparam int LAST_X = 2 + ((IMG_W - 3) / STRIDE) * STRIDE;
    localparam int LAST_Y = 2 + ((IMG_H - 3) / STRIDE) * STRIDE;

    logic [CW-1:0]     col_q, col_d, x;
    logic [RW-1:0]     row_q, row_d, y;
    logic [DATA_W-1:0] lb1_q [0:IMG_W-1];   // row y-1
    logic [DATA_W-1:0] lb2_q [0:IMG_W-1];   // row y-2
    logic [DATA_W-1:0] sr_q  [0:8];
    logic [DATA_W-1:0] win_d [0:8];
    logic [DATA_W-1:0] win_q [0:8];
    logic [DATA_W-1:0] top, mid;
    logic              out_valid_q, out_last_q;
    logic              in_ready, accept, emit, is_last;

    assign in_ready      = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.win       = win_q;

    // Position of the current pixel, next counters, emit decision and shifted window.
    always_comb begin
        // A start-of-frame beat is pixel (0,0) whatever the counters say.
        x     = bus.in_sof ? '0 : col_q;
        y     = bus.in_sof ? '0 : row_q;
        top   = lb2_q[x];
        mid   = lb1_q[x];
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (32'(x) == IMG_W - 1) begin
                col_d = '0;
                row_d = (32'(y) == IMG_H - 1) ? '0 : y + 1'b1;
            end else begin
                col_d = x + 1'b1;
                row_d = y;
            end
        end
        // x>=2 also keeps stale columns from the previous row out of any window.
        emit    = (32'(x) >= 2) && (32'(y) >= 2) &&
                  (((32'(x) - 2) % STRIDE) == 0) &&
                  (((32'(y) - 2) % STRIDE) == 0);
        is_last = emit && (32'(x) == LAST_X) && (32'(y) == LAST_Y);
        for (int r = 0; r < 3; r++) begin
            win_d[3*r]     = sr_q[3*r+1];
            win_d[3*r + 1] = sr_q[3*r+2];
            win_d[3*r + 2] = (r == 0) ? top : ((r == 1) ? mid : bus.in_data);
        end
    end

    // Pixel storage: line buffers and column shift register, updated only on accepted pixels.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2_q[x] <= mid;
            lb1_q[x] <= bus.in_data;
            sr_q     <= win_d;
        end
    end

    // Position counters and the output window register with its valid/last flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (accept && emit) begin
                out_valid_q <= 1'b1;
                out_last_q  <= is_last;
                win_q       <= win_d;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end
endmodule
